// File: rtl/rgb565_to_ycbcr_pkg.sv
// Shared image-processing constants and helpers for the RGB565 -> YCbCr converter.
// Holds the BT.601-style 8-bit fixed-point coefficients, the chroma offset and the pipeline latency.
package rgb565_to_ycbcr_pkg;

    localparam int PIPE_LAT = 3;

    localparam logic [7:0] COEF_Y_R  = 8'd77;
    localparam logic [7:0] COEF_Y_G  = 8'd150;
    localparam logic [7:0] COEF_Y_B  = 8'd29;
    localparam logic [7:0] COEF_CB_R = 8'd43;
    localparam logic [7:0] COEF_CB_G = 8'd85;
    localparam logic [7:0] COEF_CB_B = 8'd128;
    localparam logic [7:0] COEF_CR_R = 8'd128;
    localparam logic [7:0] COEF_CR_G = 8'd107;
    localparam logic [7:0] COEF_CR_B = 8'd21;

    localparam logic [16:0] CHROMA_OFFSET = 17'd32768;

    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_t;

    typedef struct packed {
        logic [15:0] y_r;
        logic [15:0] y_g;
        logic [15:0] y_b;
        logic [15:0] cb_r;
        logic [15:0] cb_g;
        logic [15:0] cb_b;
        logic [15:0] cr_r;
        logic [15:0] cr_g;
        logic [15:0] cr_b;
    } products_t;

    typedef struct packed {
        logic [16:0] y;
        logic [16:0] cb;
        logic [16:0] cr;
    } sums_t;

    function automatic logic [7:0] expand5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction

    function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
        return 16'(a) * 16'(b);
    endfunction

    // Truncating divide-by-256; anything past 16 bits clips to full scale.
    function automatic logic [7:0] take_high(input logic [16:0] s);
        return s[16] ? 8'hFF : s[15:8];
    endfunction

endpackage

// File: rtl/rgb565_to_ycbcr_if.sv
// Camera-style pixel bus into and out of the colour converter.
// master drives the per_* side and observes post_*; slave is the converter itself.
interface rgb565_to_ycbcr_if;

    logic       per_frame_vsync;
    logic       per_frame_href;
    logic       per_frame_clken;
    logic [4:0] per_img_red;
    logic [5:0] per_img_green;
    logic [4:0] per_img_blue;

    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic [7:0] post_img_y;
    logic [7:0] post_img_cb;
    logic [7:0] post_img_cr;

    modport master (
        output per_frame_vsync,
        output per_frame_href,
        output per_frame_clken,
        output per_img_red,
        output per_img_green,
        output per_img_blue,
        input  post_frame_vsync,
        input  post_frame_href,
        input  post_frame_clken,
        input  post_img_y,
        input  post_img_cb,
        input  post_img_cr
    );

    modport slave (
        input  per_frame_vsync,
        input  per_frame_href,
        input  per_frame_clken,
        input  per_img_red,
        input  per_img_green,
        input  per_img_blue,
        output post_frame_vsync,
        output post_frame_href,
        output post_frame_clken,
        output post_img_y,
        output post_img_cb,
        output post_img_cr
    );

endinterface

// File: rtl/rgb565_to_ycbcr_sync_delay.sv
// Generic fixed-depth shift register used to keep frame control signals aligned with pipelined data.
module sync_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/rgb565_to_ycbcr.sv
// Three-stage RGB565 -> YCbCr (8-bit) converter: multiply, sum, scale/saturate.
// Free-running pipeline; control signals ride alongside through sync_delay.
module rgb565_to_ycbcr #(
    parameter int PIPE_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    rgb565_to_ycbcr_if.slave    bus
);

    import rgb565_to_ycbcr_pkg::*;

    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;

    products_t  prod_q;
    sums_t      sums_q;
    logic [7:0] y_q;
    logic [7:0] cb_q;
    logic [7:0] cr_q;

    sync_t      sync_in;
    sync_t      sync_out;

    assign r8 = expand5(bus.per_img_red);
    assign g8 = expand6(bus.per_img_green);
    assign b8 = expand5(bus.per_img_blue);

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
        end else begin
            prod_q.y_r  <= mul8(COEF_Y_R,  r8);
            prod_q.y_g  <= mul8(COEF_Y_G,  g8);
            prod_q.y_b  <= mul8(COEF_Y_B,  b8);
            prod_q.cb_r <= mul8(COEF_CB_R, r8);
            prod_q.cb_g <= mul8(COEF_CB_G, g8);
            prod_q.cb_b <= mul8(COEF_CB_B, b8);
            prod_q.cr_r <= mul8(COEF_CR_R, r8);
            prod_q.cr_g <= mul8(COEF_CR_G, g8);
            prod_q.cr_b <= mul8(COEF_CR_B, b8);
        end
    end

    // The positive terms and the offset are added first so the running value never underflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            sums_q <= '0;
        end else begin
            sums_q.y  <= 17'(prod_q.y_r) + 17'(prod_q.y_g) + 17'(prod_q.y_b);
            sums_q.cb <= (17'(prod_q.cb_b) + CHROMA_OFFSET) - 17'(prod_q.cb_r) - 17'(prod_q.cb_g);
            sums_q.cr <= (17'(prod_q.cr_r) + CHROMA_OFFSET) - 17'(prod_q.cr_g) - 17'(prod_q.cr_b);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q  <= '0;
            cb_q <= '0;
            cr_q <= '0;
        end else begin
            y_q  <= take_high(sums_q.y);
            cb_q <= take_high(sums_q.cb);
            cr_q <= take_high(sums_q.cr);
        end
    end

    // The data path is hard-wired to three register stages; the sync depth must match it.
    assign sync_in = '{vsync: bus.per_frame_vsync,
                       href:  bus.per_frame_href,
                       clken: bus.per_frame_clken};

    sync_delay #(
        .WIDTH ($bits(sync_t)),
        .DEPTH (PIPE_LAT)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (sync_in),
        .dout (sync_out)
    );

    assign bus.post_frame_vsync = sync_out.vsync;
    assign bus.post_frame_href  = sync_out.href;
    assign bus.post_frame_clken = sync_out.clken;
    assign bus.post_img_y       = y_q;
    assign bus.post_img_cb      = cb_q;
    assign bus.post_img_cr      = cr_q;

endmodule

// File: tb/tb_rgb565_to_ycbcr.sv
// Directed, table-driven bench for rgb565_to_ycbcr with a 3-deep expectation queue for latency.
module tb_rgb565_to_ycbcr;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rgb565_to_ycbcr_if bus();

    rgb565_to_ycbcr #(
        .PIPE_LAT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        string      name;
    } vec_t;

    typedef struct {
        logic       vs;
        logic       hs;
        logic       ck;
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        string      name;
    } exp_t;

    localparam int NVEC = 8;

    vec_t vecs [NVEC];
    exp_t expq [$];

    int tests_run    = 0;
    int tests_failed = 0;
    int clken_seen   = 0;
    int clken_run    = 0;
    int clken_maxrun = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushIdleExpectations();
        exp_t z;
        z = '{vs: 1'b0, hs: 1'b0, ck: 1'b0, y: 8'd0, cb: 8'd0, cr: 8'd0, name: "flushed"};
        expq.delete();
        expq.push_back(z);
        expq.push_back(z);
    endtask

    task automatic checkPipe(input string tag);
        exp_t o;
        if (bus.post_frame_clken) begin
            clken_seen++;
            clken_run++;
            if (clken_run > clken_maxrun) clken_maxrun = clken_run;
        end else begin
            clken_run = 0;
        end
        if (expq.size() >= 3) begin
            o = expq.pop_front();
            checkOutput({tag, "_vsync"}, int'(bus.post_frame_vsync), int'(o.vs));
            checkOutput({tag, "_href"},  int'(bus.post_frame_href),  int'(o.hs));
            checkOutput({tag, "_clken"}, int'(bus.post_frame_clken), int'(o.ck));
            if (o.ck) begin
                checkOutput({tag, "_", o.name, "_y"},  int'(bus.post_img_y),  int'(o.y));
                checkOutput({tag, "_", o.name, "_cb"}, int'(bus.post_img_cb), int'(o.cb));
                checkOutput({tag, "_", o.name, "_cr"}, int'(bus.post_img_cr), int'(o.cr));
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input logic vs, input logic hs,
                                 input logic ck, input int idx);
        exp_t e;
        bus.per_frame_vsync = vs;
        bus.per_frame_href  = hs;
        bus.per_frame_clken = ck;
        bus.per_img_red     = vecs[idx].r;
        bus.per_img_green   = vecs[idx].g;
        bus.per_img_blue    = vecs[idx].b;
        e = '{vs: vs, hs: hs, ck: ck, y: vecs[idx].y, cb: vecs[idx].cb, cr: vecs[idx].cr,
              name: vecs[idx].name};
        expq.push_back(e);
        @(posedge clk);
        #1;
        checkPipe(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(tag, 1'b0, 1'b0, 1'b0, 0);
        end
    endtask

    // One reset cycle with a live pixel on the inputs; everything must read zero right after.
    task automatic doReset(input string tag);
        rst = 1'b1;
        bus.per_frame_vsync = 1'b1;
        bus.per_frame_href  = 1'b1;
        bus.per_frame_clken = 1'b1;
        bus.per_img_red     = 5'd31;
        bus.per_img_green   = 6'd63;
        bus.per_img_blue    = 5'd31;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput({tag, "_vsync"}, int'(bus.post_frame_vsync), 0);
        checkOutput({tag, "_href"},  int'(bus.post_frame_href),  0);
        checkOutput({tag, "_clken"}, int'(bus.post_frame_clken), 0);
        checkOutput({tag, "_y"},     int'(bus.post_img_y),       0);
        checkOutput({tag, "_cb"},    int'(bus.post_img_cb),      0);
        checkOutput({tag, "_cr"},    int'(bus.post_img_cr),      0);
        pushIdleExpectations();
    endtask

    initial begin
        vecs[0] = '{5'd31, 6'd63, 5'd31, 8'd255, 8'd128, 8'd128, "white"};
        vecs[1] = '{5'd0,  6'd0,  5'd0,  8'd0,   8'd128, 8'd128, "black"};
        vecs[2] = '{5'd31, 6'd0,  5'd0,  8'd76,  8'd85,  8'd255, "red"};
        vecs[3] = '{5'd0,  6'd63, 5'd0,  8'd149, 8'd43,  8'd21,  "green"};
        vecs[4] = '{5'd0,  6'd0,  5'd31, 8'd28,  8'd255, 8'd107, "blue"};
        vecs[5] = '{5'd16, 6'd32, 5'd16, 8'd130, 8'd128, 8'd128, "mid"};
        vecs[6] = '{5'd10, 6'd20, 5'd5,  8'd76,  8'd107, 8'd131, "mix"};
        vecs[7] = '{5'd0,  6'd63, 5'd31, 8'd178, 8'd170, 8'd0,   "cyan"};

        bus.per_frame_vsync = 1'b0;
        bus.per_frame_href  = 1'b0;
        bus.per_frame_clken = 1'b0;
        bus.per_img_red     = '0;
        bus.per_img_green   = '0;
        bus.per_img_blue    = '0;
        repeat (2) @(posedge clk);
        #1;
        doReset("reset");

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus("table", 1'b0, 1'b1, 1'b1, i);
        end
        idle("table_drain", 3);

        idle("frame_pre", 2);
        applyStimulus("vsync_a", 1'b1, 1'b0, 1'b0, 0);
        applyStimulus("vsync_a", 1'b1, 1'b0, 1'b0, 0);
        idle("frame_gap", 4);
        clken_seen   = 0;
        clken_maxrun = 0;
        for (int i = 0; i < 640; i++) begin
            applyStimulus("line", 1'b0, 1'b1, 1'b1, i % NVEC);
        end
        idle("line_tail", 3);
        applyStimulus("vsync_b", 1'b1, 1'b0, 1'b0, 0);
        applyStimulus("vsync_b", 1'b1, 1'b0, 1'b0, 0);
        idle("frame_post", 3);
        checkOutput("line_pixel_count", clken_seen, 640);
        checkOutput("line_longest_run", clken_maxrun, 640);

        for (int i = 0; i < 16; i++) begin
            applyStimulus("sparse", 1'b0, 1'b1, (i % 2) == 0, i % NVEC);
        end
        idle("sparse_drain", 3);

        for (int i = 0; i < 5; i++) begin
            applyStimulus("preflush", 1'b0, 1'b1, 1'b1, i);
        end
        doReset("midline_reset");
        clken_seen = 0;
        idle("postreset_gap", 2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("postreset", 1'b0, 1'b1, 1'b1, (i + 2) % NVEC);
        end
        idle("postreset_drain", 3);
        checkOutput("postreset_pixel_count", clken_seen, 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rgb565_to_ycbcr.md
RGB565_TO_YCBCR -- requirements
Module: rgb565_to_ycbcr

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 3, meaning the fixed input-to-output latency in clocks; only value 3 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port per_frame_vsync  input  1  camera frame sync.
REQ-005 SHALL have port per_frame_href  input  1  camera line valid.
REQ-006 SHALL have port per_frame_clken  input  1  pixel valid strobe.
REQ-007 SHALL have port per_img_red  input  5  RGB565 red.
REQ-008 SHALL have port per_img_green  input  6  RGB565 green.
REQ-009 SHALL have port per_img_blue  input  5  RGB565 blue.
REQ-010 SHALL have port post_frame_vsync  output  1  vsync delayed by PIPE_LAT.
REQ-011 SHALL have port post_frame_href  output  1  href delayed by PIPE_LAT.
REQ-012 SHALL have port post_frame_clken  output  1  clken delayed by PIPE_LAT.
REQ-013 SHALL have port post_img_y  output  8  luma; this feeds the 3x3 median filter per_img_y input.
REQ-014 SHALL have port post_img_cb  output  8  blue-difference chroma, offset 128.
REQ-015 SHALL have port post_img_cr  output  8  red-difference chroma, offset 128.

Function
REQ-016 Stage 0 (combinational) SHALL expand inputs to 8 bits by MSB replication: R8={R,R[4:2]}, G8={G,G[5:4]}, B8={B,B[4:2]}.
REQ-017 Stage 1 (register) SHALL hold nine unsigned 16-bit products: 77*R8, 150*G8, 29*B8, 43*R8, 85*G8, 128*B8, 128*R8, 107*G8, 21*B8.
REQ-018 Stage 2 (register) SHALL compute three 17-bit sums: Ysum=77R+150G+29B; Cbsum=128B-43R-85G+32768; Crsum=128R-107G-21B+32768.
REQ-019 Stage 3 (register) SHALL output bits [15:8] of each sum, with no rounding; any sum above 65535 SHALL saturate to 255.
REQ-020 Each subtraction SHALL be ordered so that no intermediate result goes negative; the 32768 offset guarantees Cbsum and Crsum >= 128.
REQ-021 The pipeline SHALL advance every clock regardless of per_frame_clken; there is no stall and no backpressure.
REQ-022 vsync, href and clken SHALL each pass through a 3-deep shift register, keeping them cycle-aligned with the data.
REQ-023 Output data SHALL be meaningful only when post_frame_clken=1; at other times it holds the pipeline contents (don't-care).
REQ-024 Back-to-back pixels (clken held high) SHALL give one output per clock, with no bubbles.
REQ-025 A vsync or href edge arriving together with a pixel SHALL emerge exactly 3 cycles later, together with that pixel's result.

Reset
REQ-026 While rst=1 at a clock edge, all pipeline and sync registers SHALL clear to 0, giving post_frame_vsync/href/clken=0 and post_img_y/cb/cr=0.
REQ-027 Reset asserted mid-line SHALL discard all in-flight pixels; no post_frame_clken pulse SHALL appear for them.
REQ-028 After rst falls, the first post_frame_clken SHALL appear no earlier than 3 cycles after the first sampled per_frame_clken=1.

Structure
REQ-029 The nine coefficients, the offset 32768 and PIPE_LAT SHALL be constants in the shared image-processing package.
REQ-030 A single sub-module sync_delay SHALL be used, parameterised by width and depth, to delay {vsync,href,clken}.

Verification
REQ-031 White (R=31,G=63,B=31), clken=1 -> 3 cycles later Y=255, Cb=128, Cr=128, post_frame_clken=1.
REQ-032 Black (0,0,0) -> Y=0, Cb=128, Cr=128; pure red R=31 -> Y=76, Cb=85, Cr=255.
REQ-033 Pure green G=63 -> Y=149, Cb=43, Cr=21; pure blue B=31 -> Y=28, Cb=255, Cr=107.
REQ-034 640-pixel line with href/clken high, framed by a vsync pulse -> 640 consecutive outputs; every control edge shifted by exactly 3 clocks.
REQ-035 rst pulsed for 1 cycle in mid-line -> all outputs 0 on the next cycle; only pixels sampled after reset produce clken pulses.
REQ-036 Sparse clken (1 of every 2 cycles) -> output clken has the same pattern delayed 3 cycles, with correct values on each pulse.
